int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 152 +++++++++++++++
 tb/tb_int_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// ---------------------------------------------------------------------------
// int_ctrl - 8-source fixed-priority interrupt controller
//
// Each source is either rising-edge (latched in a pending register until the
// CPU acknowledges it) or level (pending simply follows the registered request
// line). The lowest-indexed pending and enabled source is presented to the CPU
// as a vector. A three-state handshake follows: present (REQUEST), acknowledge
// (SERVICE), end-of-interrupt (back to IDLE). Interrupts do not nest.
//
// Parameters
//   LEVEL_SRC   per-source trigger type, 1 = level, 0 = rising edge
//   MASK_INIT   mask value loaded at reset, 1 = enabled
//
// Ports
//   clock       single clock, rising-edge active
//   reset_n     asynchronous active-low reset
//   req         interrupt request lines, bit 0 highest priority
//   mask_we     mask write strobe
//   mask_wdata  new mask value
//   ack         CPU has taken the presented interrupt (one-cycle pulse)
//   eoi         CPU has executed IRET (one-cycle pulse)
//   interrupt   interrupt request to the CPU
//   irq         vector number (source index), valid while interrupt = 1
//   pending     pending register status
//   in_service  in-service register status (one-hot or zero)
// ---------------------------------------------------------------------------
module int_ctrl #(
   parameter logic [7:0] LEVEL_SRC = 8'h00,
   parameter logic [7:0] MASK_INIT = 8'hFF
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] req,
   input  logic       mask_we,
   input  logic [7:0] mask_wdata,
   input  logic       ack,
   input  logic       eoi,
   output logic       interrupt,
   output logic [2:0] irq,
   output logic [7:0] pending,
   output logic [7:0] in_service
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] req_d_q;
   logic [7:0] edge_pend_q, edge_pend_d;
   logic [7:0] mask_q, mask_d;
   logic       int_q, int_d;
   logic [2:0] irq_q, irq_d;
   logic [7:0] isr_q, isr_d;

   logic [7:0] rise;
   logic [7:0] cand;
   logic [7:0] ack_clr;
   logic [2:0] sel;
   logic       ack_take;

   // req_d_q resets to zero, so a line already high when reset is released
   // is seen as a rise on the first clock.
   assign rise = req & ~req_d_q;

   // Level sources bypass the pending register entirely.
   assign pending = (edge_pend_q & ~LEVEL_SRC) | (req_d_q & LEVEL_SRC);
   assign cand    = pending & mask_q;

   // Lowest set index wins: scan downwards so the last hit is the lowest.
   always_comb begin
      sel = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (cand[i]) sel = 3'(i);
      end
   end

   assign ack_take = (state_q == REQUEST) && ack;

   always_comb begin
      ack_clr = 8'h00;
      if (ack_take) ack_clr[irq_q] = 1'b1;
   end

   // A rise in the same cycle as the acknowledge keeps the bit set.
   assign edge_pend_d = ((edge_pend_q & ~ack_clr) | rise) & ~LEVEL_SRC;
   assign mask_d      = mask_we ? mask_wdata : mask_q;

   // Next-state and presentation logic. The vector is latched on entry to
   // REQUEST and frozen there, so later mask/pending changes cannot alter it.
   always_comb begin
      state_d = state_q;
      int_d   = int_q;
      irq_d   = irq_q;
      isr_d   = isr_q;
      case (state_q)
         IDLE: begin
            if (cand != 8'h00) begin
               state_d = REQUEST;
               int_d   = 1'b1;
               irq_d   = sel;
            end
         end
         REQUEST: begin
            // eoi arriving with ack is deliberately ignored here.
            if (ack) begin
               state_d = SERVICE;
               int_d   = 1'b0;
               isr_d   = 8'h01 << irq_q;
            end
         end
         SERVICE: begin
            if (eoi) begin
               state_d = IDLE;
               isr_d   = 8'h00;
            end
         end
         default: begin
            state_d = IDLE;
            int_d   = 1'b0;
            isr_d   = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         req_d_q     <= 8'h00;
         edge_pend_q <= 8'h00;
         mask_q      <= MASK_INIT;
         int_q       <= 1'b0;
         irq_q       <= 3'd0;
         isr_q       <= 8'h00;
      end else begin
         state_q     <= state_d;
         req_d_q     <= req;
         edge_pend_q <= edge_pend_d;
         mask_q      <= mask_d;
         int_q       <= int_d;
         irq_q       <= irq_d;
         isr_q       <= isr_d;
      end
   end

   assign interrupt  = int_q;
   assign irq        = irq_q;
   assign in_service = isr_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

   logic       clock;
   logic       reset_n;

   // Default-parameter instance (all edge sources, MASK_INIT = 8'hFF)
   logic [7:0] req;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       ack;
   logic       eoi;
   logic       interrupt;
   logic [2:0] irq;
   logic [7:0] pending;
   logic [7:0] in_service;

   // Level instance (source 0 is level-triggered)
   logic [7:0] l_req;
   logic       l_mask_we;
   logic [7:0] l_mask_wdata;
   logic       l_ack;
   logic       l_eoi;
   logic       l_interrupt;
   logic [2:0] l_irq;
   logic [7:0] l_pending;
   logic [7:0] l_in_service;

   int n_chk  = 0;
   int n_fail = 0;

   logic [2:0] exp_q[$];
   logic [2:0] l_exp_q[$];
   logic       int_prev   = 1'b0;
   logic       l_int_prev = 1'b0;
   logic [2:0] e_irq;
   logic [2:0] l_e_irq;

   int_ctrl dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req        (req),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ack        (ack),
      .eoi        (eoi),
      .interrupt  (interrupt),
      .irq        (irq),
      .pending    (pending),
      .in_service (in_service)
   );

   int_ctrl #(.LEVEL_SRC(8'h01), .MASK_INIT(8'hFF)) dut_lvl (
      .clock      (clock),
      .reset_n    (reset_n),
      .req        (l_req),
      .mask_we    (l_mask_we),
      .mask_wdata (l_mask_wdata),
      .ack        (l_ack),
      .eoi        (l_eoi),
      .interrupt  (l_interrupt),
      .irq        (l_irq),
      .pending    (l_pending),
      .in_service (l_in_service)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitors: each new presentation pops the next expected vector.
   always @(negedge clock) begin
      if (interrupt && !int_prev) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL present_unexpected irq=%0d expected no presentation", irq);
         end else begin
            e_irq = exp_q.pop_front();
            if (irq !== e_irq) begin
               n_fail++;
               $display("FAIL present_irq actual=%0d expected=%0d", irq, e_irq);
            end
         end
      end
      int_prev = interrupt;
   end

   always @(negedge clock) begin
      if (l_interrupt && !l_int_prev) begin
         n_chk++;
         if (l_exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL lvl_present_unexpected irq=%0d expected no presentation", l_irq);
         end else begin
            l_e_irq = l_exp_q.pop_front();
            if (l_irq !== l_e_irq) begin
               n_fail++;
               $display("FAIL lvl_present_irq actual=%0d expected=%0d", l_irq, l_e_irq);
            end
         end
      end
      l_int_prev = l_interrupt;
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      req = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; ack = 1'b0; eoi = 1'b0;
      l_req = 8'h00; l_mask_we = 1'b0; l_mask_wdata = 8'h00; l_ack = 1'b0; l_eoi = 1'b0;

      step(); step();
      chk("rst_interrupt", {7'd0, interrupt}, 8'h00);
      chk("rst_irq", {5'd0, irq}, 8'h00);
      chk("rst_pending", pending, 8'h00);
      chk("rst_in_service", in_service, 8'h00);
      reset_n = 1'b1;
      step();

      // Single edge source, held high
      exp_q.push_back(3'd2);
      req = 8'h04;
      step();
      chk("t1_pending_e1", pending, 8'h04);
      chk("t1_int_e1", {7'd0, interrupt}, 8'h00);
      step();
      chk("t1_int_e2", {7'd0, interrupt}, 8'h01);
      chk("t1_irq_e2", {5'd0, irq}, 8'h02);
      step();
      chk("t1_int_hold", {7'd0, interrupt}, 8'h01);
      chk("t1_pending_hold", pending, 8'h04);
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t1_int_ack", {7'd0, interrupt}, 8'h00);
      chk("t1_isr_ack", in_service, 8'h04);
      chk("t1_pending_ack", pending, 8'h00);
      eoi = 1'b1; req = 8'h00;
      step();
      eoi = 1'b0;
      chk("t1_isr_eoi", in_service, 8'h00);

      // Priority: sources 2 and 7 together
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd7);
      req = 8'h84;
      step();
      chk("t2_pending", pending, 8'h84);
      step();
      chk("t2_irq_first", {5'd0, irq}, 8'h02);
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t2_pending_after_ack", pending, 8'h80);
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      chk("t2_int_after_eoi", {7'd0, interrupt}, 8'h00);
      step();
      chk("t2_int_second", {7'd0, interrupt}, 8'h01);
      chk("t2_irq_second", {5'd0, irq}, 8'h07);
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t2_isr_second", in_service, 8'h80);
      chk("t2_pending_clear", pending, 8'h00);
      eoi = 1'b1; req = 8'h00;
      step();
      eoi = 1'b0;

      // Masking blocks selection, not pending; mask change cannot withdraw
      mask_we = 1'b1; mask_wdata = 8'hFB;
      step();
      mask_we = 1'b0;
      req = 8'h04;
      step();
      step();
      chk("t3_int_masked", {7'd0, interrupt}, 8'h00);
      chk("t3_pending_masked", pending, 8'h04);
      exp_q.push_back(3'd2);
      mask_we = 1'b1; mask_wdata = 8'hFF;
      step();
      mask_we = 1'b0;
      step();
      chk("t3_int_unmasked", {7'd0, interrupt}, 8'h01);
      chk("t3_irq_unmasked", {5'd0, irq}, 8'h02);
      mask_we = 1'b1; mask_wdata = 8'h00;
      step();
      mask_we = 1'b0;
      chk("t3_int_mask_hold", {7'd0, interrupt}, 8'h01);
      chk("t3_irq_mask_hold", {5'd0, irq}, 8'h02);
      mask_we = 1'b1; mask_wdata = 8'hFF; ack = 1'b1;
      step();
      mask_we = 1'b0; ack = 1'b0;
      eoi = 1'b1; req = 8'h00;
      step();
      eoi = 1'b0;

      // Hold and no nesting
      exp_q.push_back(3'd5);
      exp_q.push_back(3'd0);
      req = 8'h20;
      step();
      step();
      chk("t4_irq5", {5'd0, irq}, 8'h05);
      req = 8'h21;
      step();
      chk("t4_pending_21", pending, 8'h21);
      chk("t4_irq_hold1", {5'd0, irq}, 8'h05);
      step();
      chk("t4_irq_hold2", {5'd0, irq}, 8'h05);
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t4_isr_20", in_service, 8'h20);
      step();
      step();
      chk("t4_no_nest_int", {7'd0, interrupt}, 8'h00);
      chk("t4_no_nest_pending", pending, 8'h01);
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      chk("t4_int_after_eoi", {7'd0, interrupt}, 8'h00);
      step();
      chk("t4_irq0", {5'd0, irq}, 8'h00);
      chk("t4_int0", {7'd0, interrupt}, 8'h01);
      // ack and eoi together act as ack only
      ack = 1'b1; eoi = 1'b1;
      step();
      ack = 1'b0; eoi = 1'b0;
      chk("t4_ackeoi_isr", in_service, 8'h01);
      // ack in SERVICE is ignored
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t4_stray_ack_isr", in_service, 8'h01);
      eoi = 1'b1; req = 8'h00;
      step();
      eoi = 1'b0;
      chk("t4_isr_clear", in_service, 8'h00);
      // eoi in IDLE is ignored
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      chk("t4_stray_eoi_int", {7'd0, interrupt}, 8'h00);

      // Rise coinciding with ack keeps pending; re-presented after eoi
      exp_q.push_back(3'd3);
      exp_q.push_back(3'd3);
      req = 8'h08;
      step();
      step();
      chk("t5_irq3", {5'd0, irq}, 8'h03);
      req = 8'h00;
      step();
      req = 8'h08; ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t5_set_wins_pending", pending, 8'h08);
      chk("t5_isr_08", in_service, 8'h08);
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      step();
      chk("t5_represent_int", {7'd0, interrupt}, 8'h01);
      chk("t5_represent_irq", {5'd0, irq}, 8'h03);
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t5_pending_clear", pending, 8'h00);
      eoi = 1'b1; req = 8'h00;
      step();
      eoi = 1'b0;

      // Asynchronous reset mid-SERVICE, mask restored, held req seen as rise
      exp_q.push_back(3'd4);
      exp_q.push_back(3'd1);
      req = 8'h10;
      step();
      step();
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t6_isr_10", in_service, 8'h10);
      mask_we = 1'b1; mask_wdata = 8'h00;
      step();
      mask_we = 1'b0;
      req = 8'h02;
      reset_n = 1'b0;
      #1;
      chk("t6_async_isr", in_service, 8'h00);
      chk("t6_async_int", {7'd0, interrupt}, 8'h00);
      chk("t6_async_pending", pending, 8'h00);
      step();
      step();
      chk("t6_pending_in_reset", pending, 8'h00);
      reset_n = 1'b1;
      step();
      chk("t6_rise_after_reset", pending, 8'h02);
      chk("t6_int_e1", {7'd0, interrupt}, 8'h00);
      step();
      chk("t6_int_mask_init", {7'd0, interrupt}, 8'h01);
      chk("t6_irq1", {5'd0, irq}, 8'h01);
      ack = 1'b1;
      step();
      ack = 1'b0;
      eoi = 1'b1; req = 8'h00;
      step();
      eoi = 1'b0;

      // Level source 0 on the second instance
      l_exp_q.push_back(3'd0);
      l_exp_q.push_back(3'd0);
      l_req = 8'h01;
      step();
      chk("lv_pending_e1", l_pending, 8'h01);
      step();
      chk("lv_int", {7'd0, l_interrupt}, 8'h01);
      chk("lv_irq", {5'd0, l_irq}, 8'h00);
      l_ack = 1'b1;
      step();
      l_ack = 1'b0;
      chk("lv_isr", l_in_service, 8'h01);
      chk("lv_pending_kept", l_pending, 8'h01);
      l_eoi = 1'b1;
      step();
      l_eoi = 1'b0;
      chk("lv_int_after_eoi", {7'd0, l_interrupt}, 8'h00);
      step();
      chk("lv_represent_int", {7'd0, l_interrupt}, 8'h01);
      chk("lv_represent_irq", {5'd0, l_irq}, 8'h00);
      l_ack = 1'b1; l_req = 8'h00;
      step();
      l_ack = 1'b0;
      chk("lv_pending_drop", l_pending, 8'h00);
      l_eoi = 1'b1;
      step();
      l_eoi = 1'b0;
      step();
      chk("lv_no_represent", {7'd0, l_interrupt}, 8'h00);

      step(); step();
      chk("sb_drained", 8'(exp_q.size()), 8'h00);
      chk("lv_sb_drained", 8'(l_exp_q.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
